// File: rtl/gen_collector.sv
// gen_collector: caller-side driver for a two-output ready/valid/done generator.
// Launches the generator with captured arguments, accepts every yielded tuple,
// keeps the first DEPTH of them along with a count and a running sum, then replays
// the kept tuples to its own caller over the same ready/valid/done protocol.
module gen_collector #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic [WIDTH-1:0] gen_base,
  output logic [WIDTH-1:0] gen_limit,
  output logic [WIDTH-1:0] gen_step,
  output logic             gen_start,
  output logic             gen_ready,
  input  logic             gen_valid,
  input  logic             gen_done,
  input  logic [WIDTH-1:0] gen_0,
  input  logic [WIDTH-1:0] gen_1
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra bit so the write pointer can express "buffer full" (== DEPTH).
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DepthP = ptr_t'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StCollect,
    StDrain,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] buf0_q [DEPTH];
  logic [WIDTH-1:0] buf1_q [DEPTH];

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] arg_base_q, arg_base_d;
  logic [WIDTH-1:0] arg_limit_q, arg_limit_d;
  logic [WIDTH-1:0] arg_step_q, arg_step_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  // High during the first COLLECT cycle, when the generator's done is still stale.
  logic             first_q, first_d;

  logic gen_xfer;
  logic gen_fin;
  logic out_xfer;
  logic last_rd;
  logic buf_we;

  assign gen_xfer = (state_q == StCollect) && gen_valid;
  assign gen_fin  = (state_q == StCollect) && !first_q && gen_done && !gen_valid;
  assign out_xfer = (state_q == StDrain) && _ready;
  assign last_rd  = ((rd_ptr_q + ptr_t'(1)) == wr_ptr_q);
  assign buf_we   = gen_xfer && !_start && (wr_ptr_q < DepthP);

  // State register.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; _start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (_start) begin
      state_d = StLaunch;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StLaunch:  state_d = StCollect;
        StCollect: begin
          if (gen_fin) begin
            state_d = (wr_ptr_q != '0) ? StDrain : StFinish;
          end
        end
        StDrain: begin
          if (out_xfer && last_rd) begin
            state_d = StFinish;
          end
        end
        StFinish:  state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    gen_start = 1'b0;
    gen_ready = 1'b0;
    _valid    = 1'b0;
    _done     = 1'b0;
    unique case (state_q)
      StLaunch:  gen_start = 1'b1;
      StCollect: gen_ready = 1'b1;
      StDrain:   _valid    = 1'b1;
      StFinish:  _done     = 1'b1;
      default:   ;
    endcase
  end

  // Datapath next-state: argument capture, statistics, pointers and replay registers.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    arg_base_d  = arg_base_q;
    arg_limit_d = arg_limit_q;
    arg_step_d  = arg_step_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    first_d     = (state_q == StLaunch) && !_start;

    if (_start) begin
      arg_base_d  = base;
      arg_limit_d = limit;
      arg_step_d  = step;
      count_d     = '0;
      sum_d       = '0;
      ovf_d       = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else begin
      if (gen_xfer) begin
        count_d = count_q + WIDTH'(1);
        sum_d   = sum_q + gen_0;
        if (wr_ptr_q < DepthP) begin
          wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      // Preload the first entry so it is on the outputs in the first DRAIN cycle.
      if (gen_fin && (wr_ptr_q != '0)) begin
        out0_d = buf0_q[0];
        out1_d = buf1_q[0];
      end
      if (out_xfer) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
        // After the last entry the outputs keep their final value.
        if (!last_rd) begin
          out0_d = buf0_q[rd_ptr_d[AW-1:0]];
          out1_d = buf1_q[rd_ptr_d[AW-1:0]];
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      arg_base_q  <= '0;
      arg_limit_q <= '0;
      arg_step_q  <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      first_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      arg_base_q  <= arg_base_d;
      arg_limit_q <= arg_limit_d;
      arg_step_q  <= arg_step_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      first_q     <= first_d;
    end
  end

  // Tuple buffer; contents are only meaningful below wr_ptr, so no reset is needed.
  always_ff @(posedge _clock) begin
    if (buf_we) begin
      buf0_q[wr_ptr_q[AW-1:0]] <= gen_0;
      buf1_q[wr_ptr_q[AW-1:0]] <= gen_1;
    end
  end

  assign _0        = out0_q;
  assign _1        = out1_q;
  assign count     = count_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign gen_base  = arg_base_q;
  assign gen_limit = arg_limit_q;
  assign gen_step  = arg_step_q;

endmodule

// File: tb/tb_gen_collector.sv
// Bench for gen_collector: a behavioural range generator drives the generator side,
// and each run is checked against the sequence the range arguments define.
module tb_gen_collector;

  localparam int W = 32;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base, limit, step;
  logic          rdy;
  logic          valid_o, done_o;
  logic [W-1:0]  o0, o1, count_o, sum_o;
  logic          ovf_o;
  logic [W-1:0]  gen_base, gen_limit, gen_step;
  logic          gen_start, gen_ready;
  logic          gen_valid, gen_done;
  logic [W-1:0]  gen_0, gen_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gen_collector #(.WIDTH(W), .DEPTH(D)) dut (
    ._clock    (clk),
    ._reset    (rst),
    ._start    (start),
    .base      (base),
    .limit     (limit),
    .step      (step),
    ._ready    (rdy),
    ._valid    (valid_o),
    ._done     (done_o),
    ._0        (o0),
    ._1        (o1),
    .count     (count_o),
    .sum       (sum_o),
    .overflow  (ovf_o),
    .gen_base  (gen_base),
    .gen_limit (gen_limit),
    .gen_step  (gen_step),
    .gen_start (gen_start),
    .gen_ready (gen_ready),
    .gen_valid (gen_valid),
    .gen_done  (gen_done),
    .gen_0     (gen_0),
    .gen_1     (gen_1)
  );

  // Range generator model: yields (v, v) or (v, ~v) for v = base; v < limit; v += step.
  // Its done stays high (stale) until one cycle after a new start.
  int g_cur, g_lim, g_stp;
  bit g_act, g_pend, g_donq, g_stall;
  bit m_stall, m_early, m_alt;

  always @(posedge clk) begin
    if (rst) begin
      g_act   <= 1'b0;
      g_pend  <= 1'b0;
      g_donq  <= 1'b1;
      g_stall <= 1'b0;
    end else if (gen_start) begin
      g_act  <= 1'b1;
      g_pend <= 1'b1;
      g_cur  <= $signed(gen_base);
      g_lim  <= $signed(gen_limit);
      g_stp  <= $signed(gen_step);
    end else if (g_act) begin
      g_pend  <= 1'b0;
      g_stall <= m_stall && ($urandom_range(0, 2) == 0);
      if (g_pend) g_donq <= 1'b0;
      else if (g_cur >= g_lim) g_donq <= 1'b1;
      if (!g_pend && gen_valid && gen_ready) g_cur <= g_cur + g_stp;
    end
  end

  assign gen_valid = g_act && !g_pend && (g_cur < g_lim) && !g_stall;
  assign gen_done  = (!g_act || g_pend) ? g_donq :
                     ((g_cur >= g_lim) || (m_early && gen_valid && (g_cur + g_stp >= g_lim)));
  assign gen_0     = g_cur;
  assign gen_1     = m_alt ? ~g_cur : g_cur;

  // Launch one run and check its replay, statistics and completion pulse.
  // rmode: 0 ready always high, 1 ready pattern 1-0-0-1, 2 random ready.
  task automatic run(input int b, input int l, input int s, input int rmode,
                     input bit st, input bit ea, input bit al);
    logic [W-1:0] e0[$], e1[$], a0[$], a1[$];
    logic [W-1:0] esum = '0;
    int n = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit r, pv, pr, seen_v, bub, got_done;
    logic [W-1:0] p0, p1;
    int vcyc = 0;
    for (int v = b; v < l; v += s) begin
      n++;
      esum = esum + W'(v);
      if (n <= D) begin
        e0.push_back(W'(v));
        e1.push_back(al ? ~W'(v) : W'(v));
      end
    end
    m_stall = st; m_early = ea; m_alt = al;
    base = W'(b); limit = W'(l); step = W'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (gen_start !== 1'b1 || gen_base !== W'(b) || gen_limit !== W'(l) || gen_step !== W'(s))
      begin
      errors++;
      $display("FAIL launch: gen_start=%0b base=%0d limit=%0d step=%0d, want 1 %0d %0d %0d",
               gen_start, gen_base, gen_limit, gen_step, b, l, s);
    end
    @(negedge clk);
    checks++;
    if (gen_start !== 1'b0) begin
      errors++;
      $display("FAIL launch_once: gen_start=%0b want 0", gen_start);
    end
    pv = 0; pr = 1; seen_v = 0; bub = 0; got_done = 0; p0 = '0; p1 = '0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = pat[c % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy = r;
      if (pv && !pr) begin
        checks++;
        if (valid_o !== 1'b1 || o0 !== p0 || o1 !== p1) begin
          errors++;
          $display("FAIL hold: valid=%0b out=(%0d,%0d) want 1 (%0d,%0d)",
                   valid_o, o0, o1, p0, p1);
        end
      end
      if (valid_o === 1'b1) begin
        seen_v = 1;
        vcyc++;
        if (r) begin
          a0.push_back(o0);
          a1.push_back(o1);
        end
      end else if (seen_v && done_o !== 1'b1) begin
        bub = 1;
      end
      if (done_o === 1'b1) begin
        got_done = 1;
        checks++;
        if (valid_o !== 1'b0) begin
          errors++;
          $display("FAIL done_valid: valid=%0b during done, want 0", valid_o);
        end
      end
      pv = valid_o; pr = r; p0 = o0; p1 = o1;
      if (!got_done) @(negedge clk);
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL timeout: no done pulse for base=%0d limit=%0d step=%0d", b, l, s);
    end
    checks++;
    if (count_o !== W'(n)) begin
      errors++;
      $display("FAIL count: got %0d want %0d", count_o, n);
    end
    checks++;
    if (sum_o !== esum) begin
      errors++;
      $display("FAIL sum: got %0d want %0d", $signed(sum_o), $signed(esum));
    end
    checks++;
    if (ovf_o !== (n > D)) begin
      errors++;
      $display("FAIL overflow: got %0b want %0b", ovf_o, (n > D));
    end
    checks++;
    if (a0.size() != e0.size()) begin
      errors++;
      $display("FAIL replay_len: got %0d want %0d", a0.size(), e0.size());
    end else begin
      foreach (e0[i]) begin
        checks++;
        if (a0[i] !== e0[i] || a1[i] !== e1[i]) begin
          errors++;
          $display("FAIL replay[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   i, $signed(a0[i]), $signed(a1[i]), $signed(e0[i]), $signed(e1[i]));
        end
      end
    end
    if (rmode == 0) begin
      checks++;
      if (vcyc != e0.size() || bub) begin
        errors++;
        $display("FAIL no_bubble: valid cycles %0d gap %0b, want %0d and 0",
                 vcyc, bub, e0.size());
      end
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || valid_o !== 1'b0 || gen_ready !== 1'b0 || count_o !== W'(n)) begin
      errors++;
      $display("FAIL idle: done=%0b valid=%0b gen_ready=%0b count=%0d, want 0 0 0 %0d",
               done_o, valid_o, gen_ready, count_o, n);
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base = 7; limit = 9; step = 1; rdy = 1'b1;
    m_stall = 0; m_early = 0; m_alt = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b0 || gen_start !== 1'b0 || gen_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: valid=%0b done=%0b gen_start=%0b gen_ready=%0b, want 0",
               valid_o, done_o, gen_start, gen_ready);
    end
    checks++;
    if (count_o !== '0 || sum_o !== '0 || ovf_o !== 1'b0 || o0 !== '0 || o1 !== '0) begin
      errors++;
      $display("FAIL reset_data: count=%0d sum=%0d ovf=%0b out=(%0d,%0d), want 0",
               count_o, sum_o, ovf_o, o0, o1);
    end
    checks++;
    if (gen_base !== '0 || gen_limit !== '0 || gen_step !== '0) begin
      errors++;
      $display("FAIL reset_args: %0d %0d %0d, want 0 0 0", gen_base, gen_limit, gen_step);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (gen_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: gen_start=%0b want 0", gen_start);
    end
  endtask

  task automatic test_basic();        run(0, 10, 2, 0, 0, 0, 0); endtask
  task automatic test_empty();        run(5, 5, 1, 0, 0, 0, 0);  endtask
  task automatic test_overflow();     run(0, 20, 1, 0, 0, 0, 0); endtask
  task automatic test_backpressure(); run(1, 11, 3, 1, 0, 0, 0); endtask

  task automatic test_reset_mid();
    bit ok = 0;
    m_stall = 0; m_early = 0; m_alt = 0;
    base = 0; limit = 20; step = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (count_o === W'(2)) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_mid_wait: count=%0d never reached 2", count_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || gen_ready !== 1'b0 || count_o !== '0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b gen_ready=%0b count=%0d done=%0b, want 0 0 0 0",
               valid_o, gen_ready, count_o, done_o);
    end
    ok = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o !== 1'b0 || valid_o !== 1'b0) ok = 1;
    end
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after reset, want none");
    end
    run(0, 10, 2, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    bit ok = 0;
    m_stall = 0; m_early = 0; m_alt = 0;
    rdy = 1'b1;
    base = 0; limit = 10; step = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_wait: run A never reached replay");
    end
    @(negedge clk);
    run(0, 6, 3, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 14; k++) begin
      int b = int'($urandom_range(0, 80)) - 40;
      int s = int'($urandom_range(1, 6));
      int l = b + int'($urandom_range(0, 60));
      run(b, l, s, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    run(3, 9, 2, 2, 1, 1, 1);
    run(-8, 8, 1, 0, 0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
